// File: rtl/data_bus_responder_pkg.sv
// dbus_pkg
// Shared constants and types for the data-memory bus responder.
// Contents: default region base addresses, I/O register offsets, the ID
// register value, the address-decode result enum and a helper that tells
// whether a write to a given I/O offset is refused.
// Optional feature macro: DBUS_CYCLE_COUNTER_EN (cycle counter present;
// it also selects the low byte of the ID value).
`timescale 1ns/1ps

package dbus_pkg;

   localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;
   localparam logic [31:0] DEFAULT_IO_BASE   = 32'h1001_0400;

   // The I/O window is four word registers.
   localparam logic [31:0] IO_REGION_BYTES = 32'd16;

   localparam logic [3:0] IO_GPIO_OUT    = 4'h0;
   localparam logic [3:0] IO_GPIO_IN     = 4'h4;
   localparam logic [3:0] IO_CYCLE_COUNT = 4'h8;
   localparam logic [3:0] IO_ID          = 4'hC;

   // The low byte of the ID tells software whether the counter exists.
`ifdef DBUS_CYCLE_COUNTER_EN
   localparam logic [31:0] DBUS_ID = 32'hDB05_0001;
`else
   localparam logic [31:0] DBUS_ID = 32'hDB05_0000;
`endif

   typedef enum logic [1:0] {
      HIT_RAM,
      HIT_IO,
      HIT_NONE
   } hit_t;

   // Writes to read-only I/O registers are illegal accesses. Without the
   // counter, its offset behaves as a read-only zero register.
   function automatic logic ioWriteIllegal(input logic [3:0] offset);
`ifdef DBUS_CYCLE_COUNTER_EN
      return (offset == IO_GPIO_IN) || (offset == IO_ID);
`else
      return (offset == IO_GPIO_IN) || (offset == IO_ID) ||
             (offset == IO_CYCLE_COUNT);
`endif
   endfunction

endpackage

// File: rtl/data_bus_responder_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for bringing asynchronous pins into the clk domain.
// Ports:
//   clk   - sampling clock, rising edge
//   reset - asynchronous reset, active-low, clears both stages
//   d     - asynchronous input bus (WIDTH bits)
//   q     - synchronized output bus (WIDTH bits), two edges behind d
`timescale 1ns/1ps

module sync_2ff #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stageOne;
   logic [WIDTH-1:0] stageTwo;

   // The first stage may go metastable; only the second stage is consumed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stageOne <= '0;
         stageTwo <= '0;
      end else begin
         stageOne <= d;
         stageTwo <= stageOne;
      end
   end

   assign q = stageTwo;

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder
// Responder end of the core's data-memory bus. Decodes a word-addressed RAM
// region and a small memory-mapped I/O window (GPIO out, synchronized GPIO
// in, cycle counter, ID) and answers loads combinationally in the same cycle.
// Illegal accesses read 0, have no effect, and set a sticky error flag.
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous reset, active-low
//   MemWrite  - write strobe for the current cycle
//   Address   - byte address from the core ALU
//   WriteData - store data
//   ReadData  - load data, combinational
//   gpio_in   - asynchronous external input pins
//   gpio_out  - registered output port
//   bus_error - sticky illegal-access flag
// Optional feature macro: DBUS_CYCLE_COUNTER_EN enables the CYCLE_COUNT
// register; without it offset +8 reads 0 and writing it is illegal.
`timescale 1ns/1ps

import dbus_pkg::*;

module data_bus_responder #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          MEMORY_DEPTH = 32,
   parameter logic [31:0] DATA_BASE    = DEFAULT_DATA_BASE,
   parameter logic [31:0] IO_BASE      = DEFAULT_IO_BASE,
   parameter int          GPIO_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemWrite,
   input  logic [31:0]           Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] ReadData,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic                  bus_error
);

   localparam int          IDX_W     = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(4 * MEMORY_DEPTH);

   logic [31:0]           ramOffset;
   logic [31:0]           ioOffset;
   logic [3:0]            ioReg;
   logic [IDX_W-1:0]      wordIndex;
   hit_t                  hit;
   logic                  misaligned;
   logic                  illegal;
   logic                  ramWrite;
   logic                  gpioWrite;
   logic [DATA_WIDTH-1:0] ram [MEMORY_DEPTH];
   logic [GPIO_WIDTH-1:0] gpioOutReg;
   logic [GPIO_WIDTH-1:0] gpioInSync;
   logic [DATA_WIDTH-1:0] gpioOutExt;
   logic [DATA_WIDTH-1:0] gpioInExt;
   logic [DATA_WIDTH-1:0] countRead;
   logic                  errorFlag;

   // Region decode. Offsets are taken relative to each base and compared
   // against the region size, which keeps the bounds check free of any
   // overflow in base + size.
   always_comb begin
      ramOffset  = Address - DATA_BASE;
      ioOffset   = Address - IO_BASE;
      ioReg      = ioOffset[3:0];
      wordIndex  = ramOffset[IDX_W+1:2];
      misaligned = |Address[1:0];
      if ((Address >= DATA_BASE) && (ramOffset < RAM_BYTES)) begin
         hit = HIT_RAM;
      end else if ((Address >= IO_BASE) && (ioOffset < IO_REGION_BYTES)) begin
         hit = HIT_IO;
      end else begin
         hit = HIT_NONE;
      end
   end

   // Plain unmapped reads are legal: the core drives ALU results onto
   // Address every cycle, so only writes or misalignment count as errors.
   always_comb begin
      illegal = misaligned ||
                (MemWrite && (hit == HIT_NONE)) ||
                (MemWrite && (hit == HIT_IO) && ioWriteIllegal(ioReg));
      ramWrite  = MemWrite && !illegal && (hit == HIT_RAM);
      gpioWrite = MemWrite && !illegal && (hit == HIT_IO) && (ioReg == IO_GPIO_OUT);
   end

   // Zero-extend the narrow GPIO values onto the bus width.
   always_comb begin
      gpioOutExt = '0;
      gpioInExt  = '0;
      gpioOutExt[GPIO_WIDTH-1:0] = gpioOutReg;
      gpioInExt[GPIO_WIDTH-1:0]  = gpioInSync;
   end

   // Combinational read mux. Stores commit at the edge, so a load of the
   // location being written in the same cycle sees the old contents.
   always_comb begin
      ReadData = '0;
      if (!illegal) begin
         if (hit == HIT_RAM) begin
            ReadData = ram[wordIndex];
         end else if (hit == HIT_IO) begin
            case (ioReg)
               IO_GPIO_OUT:    ReadData = gpioOutExt;
               IO_GPIO_IN:     ReadData = gpioInExt;
               IO_CYCLE_COUNT: ReadData = countRead;
               IO_ID:          ReadData = DATA_WIDTH'(DBUS_ID);
               default:        ReadData = '0;
            endcase
         end
      end
   end

   // Data RAM. It is cleared on reset so software sees a known image.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEMORY_DEPTH; i++) begin
            ram[i] <= '0;
         end
      end else if (ramWrite) begin
         ram[wordIndex] <= WriteData;
      end
   end

   // GPIO output register; only the low GPIO_WIDTH bits of the store land.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpioOutReg <= '0;
      end else if (gpioWrite) begin
         gpioOutReg <= WriteData[GPIO_WIDTH-1:0];
      end
   end

   assign gpio_out = gpioOutReg;

   sync_2ff #(
      .WIDTH(GPIO_WIDTH)
   ) gpioSync (
      .clk   (clk),
      .reset (reset),
      .d     (gpio_in),
      .q     (gpioInSync)
   );

`ifdef DBUS_CYCLE_COUNTER_EN
   logic                  countWrite;
   logic [DATA_WIDTH-1:0] cycleCount;

   assign countWrite = MemWrite && !illegal && (hit == HIT_IO) &&
                       (ioReg == IO_CYCLE_COUNT);

   // Free-running cycle counter; a store replaces that cycle's increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycleCount <= '0;
      end else if (countWrite) begin
         cycleCount <= WriteData;
      end else begin
         cycleCount <= cycleCount + 1'b1;
      end
   end

   assign countRead = cycleCount;
`else
   assign countRead = '0;
`endif

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         errorFlag <= 1'b0;
      end else if (illegal) begin
         errorFlag <= 1'b1;
      end
   end

   assign bus_error = errorFlag;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder
// Scoreboard bench for data_bus_responder: every stimulus cycle pushes the
// expected ReadData / bus_error / gpio_out into a queue, and a monitor on the
// falling edge pops and compares. Expectations come from a reference model
// of the memory map kept as plain arrays and a pin-history queue.
`timescale 1ns/1ps

module tb_data_bus_responder;

   localparam logic [31:0] DB   = 32'h1001_0000;
   localparam logic [31:0] IOB  = 32'h1001_0400;
   localparam int          DEPTH = 32;
   localparam int          GW    = 8;
`ifdef DBUS_CYCLE_COUNTER_EN
   localparam bit          CNT_EN = 1'b1;
   localparam logic [31:0] REF_ID = 32'hDB05_0001;
`else
   localparam bit          CNT_EN = 1'b0;
   localparam logic [31:0] REF_ID = 32'hDB05_0000;
`endif

   logic          clk;
   logic          reset;
   logic          MemWrite;
   logic [31:0]   Address;
   logic [31:0]   WriteData;
   logic [31:0]   ReadData;
   logic [GW-1:0] gpio_in;
   logic [GW-1:0] gpio_out;
   logic          bus_error;

   typedef struct {
      logic [31:0]   rd;
      logic          err;
      logic [GW-1:0] gpo;
      string         name;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   logic [31:0]   mRam [DEPTH];
   logic [GW-1:0] mGpio;
   logic [31:0]   mCount;
   logic          mErr;
   logic [GW-1:0] pinHist[$];

   data_bus_responder #(
      .DATA_WIDTH   (32),
      .MEMORY_DEPTH (DEPTH),
      .DATA_BASE    (DB),
      .IO_BASE      (IOB),
      .GPIO_WIDTH   (GW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .bus_error (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronized pin value: whatever was on the pins two edges ago.
   function automatic logic [GW-1:0] syncedPins();
      if (pinHist.size() < 2) return '0;
      return pinHist[pinHist.size() - 2];
   endfunction

   // Memory-map rules evaluated directly on the byte address.
   function automatic void refEval(input bit we, input logic [31:0] addr,
                                   output logic [31:0] rd, output bit ill);
      longint a     = longint'(addr);
      bit     inRam = (a >= longint'(DB)) && (a < longint'(DB) + 4 * DEPTH);
      bit     inIo  = (a >= longint'(IOB)) && (a < longint'(IOB) + 16);
      bit     mis   = (a % 4) != 0;
      longint off   = a - longint'(IOB);
      ill = mis || (we && !inRam && !inIo) ||
            (we && inIo && (off == 4 || off == 12 || (!CNT_EN && off == 8)));
      rd = 32'h0;
      if (!ill) begin
         if (inRam) rd = mRam[(a - longint'(DB)) / 4];
         else if (inIo) begin
            if (off == 0)       rd = 32'(mGpio);
            else if (off == 4)  rd = 32'(syncedPins());
            else if (off == 8)  rd = CNT_EN ? mCount : 32'h0;
            else if (off == 12) rd = REF_ID;
         end
      end
   endfunction

   // State change at the rising edge that follows the given bus cycle.
   function automatic void edgeUpdate(input bit we, input logic [31:0] addr,
                                      input logic [31:0] wd, input bit ill,
                                      input logic [GW-1:0] pins);
      longint a      = longint'(addr);
      bit     loaded = 1'b0;
      if (ill) mErr = 1'b1;
      else if (we) begin
         if (a >= longint'(DB) && a < longint'(DB) + 4 * DEPTH)
            mRam[(a - longint'(DB)) / 4] = wd;
         else if (a == longint'(IOB))
            mGpio = wd[GW-1:0];
         else if (a == longint'(IOB) + 8 && CNT_EN) begin
            mCount = wd;
            loaded = 1'b1;
         end
      end
      if (!loaded) mCount = mCount + 32'd1;
      pinHist.push_back(pins);
   endfunction

   function automatic void clearModel();
      for (int i = 0; i < DEPTH; i++) mRam[i] = 32'h0;
      mGpio  = '0;
      mCount = 32'h0;
      mErr   = 1'b0;
      pinHist.delete();
   endfunction

   // One bus cycle: drive at posedge+1, queue the expectation, advance model.
   task automatic applyStimulus(input bit we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [GW-1:0] pins,
                                input string name);
      logic [31:0] rd;
      bit          ill;
      exp_t        e;
      MemWrite  = we;
      Address   = addr;
      WriteData = wd;
      gpio_in   = pins;
      refEval(we, addr, rd, ill);
      e.rd = rd; e.err = mErr; e.gpo = mGpio; e.name = name;
      expQ.push_back(e);
      edgeUpdate(we, addr, wd, ill, pins);
      @(posedge clk);
      #1;
   endtask

   // Reset asserted mid-cycle while a RAM write is in flight; released
   // before the next edge so that edge performs the first increment.
   task automatic applyReset();
      logic [31:0] rd;
      bit          ill;
      exp_t        e;
      MemWrite  = 1'b1;
      Address   = DB + 32'd8;
      WriteData = $urandom;
      #1 reset  = 1'b0;
      clearModel();
      refEval(1'b1, DB + 32'd8, rd, ill);
      e.rd = rd; e.err = mErr; e.gpo = mGpio; e.name = "resetMidWrite";
      expQ.push_back(e);
      @(negedge clk);
      #1 MemWrite = 1'b0;
      #1 reset    = 1'b1;
      edgeUpdate(1'b0, DB + 32'd8, 32'h0, 1'b0, gpio_in);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input exp_t e);
      checks += 3;
      if (ReadData !== e.rd) begin
         failures++;
         $display("[TB] FAIL %s readData actual=%h required=%h", e.name, ReadData, e.rd);
      end
      if (bus_error !== e.err) begin
         failures++;
         $display("[TB] FAIL %s busError actual=%b required=%b", e.name, bus_error, e.err);
      end
      if (gpio_out !== e.gpo) begin
         failures++;
         $display("[TB] FAIL %s gpioOut actual=%h required=%h", e.name, gpio_out, e.gpo);
      end
   endtask

   // Monitor: outputs are compared mid-cycle whenever a cycle is pending.
   always @(negedge clk) begin
      if (expQ.size() != 0) checkOutput(expQ.pop_front());
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] time limit");
   end

   function automatic logic [31:0] randomAddress();
      case ($urandom_range(0, 11))
         0, 1, 2, 3, 4: return DB + 32'(4 * $urandom_range(0, DEPTH - 1));
         5, 6, 7:       return IOB + 32'(4 * $urandom_range(0, 3));
         8:             return DB + 32'($urandom_range(0, 4 * DEPTH - 1));
         9:             return DB + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
         10:            return DB - 32'd4;
         default:       return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [GW-1:0] pins;
      reset     = 1'b1;
      MemWrite  = 1'b0;
      Address   = 32'h0;
      WriteData = 32'h0;
      gpio_in   = '0;
      clearModel();
      @(posedge clk);
      #1;
      applyReset();

      applyStimulus(1'b0, DB + 32'd8, 32'h0, 8'h00, "resetRead");
      applyStimulus(1'b1, DB + 32'd4, 32'hCAFE_F00D, 8'h00, "ramWriteSameCycle");
      applyStimulus(1'b0, DB + 32'd4, 32'h0, 8'h00, "ramReadBack");
      applyStimulus(1'b0, DB + 32'd8, 32'h0, 8'h00, "ramNeighbour");
      applyStimulus(1'b1, IOB, 32'h0000_01A5, 8'h00, "gpioWrite");
      applyStimulus(1'b0, IOB, 32'h0, 8'h00, "gpioReadBack");
      applyStimulus(1'b0, IOB + 32'd4, 32'h0, 8'h3C, "gpioInEdgeN");
      applyStimulus(1'b0, IOB + 32'd4, 32'h0, 8'h3C, "gpioInAfterN");
      applyStimulus(1'b0, IOB + 32'd4, 32'h0, 8'h3C, "gpioInAfterN1");
      applyStimulus(1'b0, IOB + 32'd12, 32'h0, 8'h3C, "idRead");
      applyStimulus(1'b0, DB + 32'd128, 32'h0, 8'h3C, "ramTopUnmapped");
      applyStimulus(1'b0, DB + 32'd124, 32'h0, 8'h3C, "ramLastWord");
      applyStimulus(1'b1, IOB + 32'd8, 32'hFFFF_FFFE, 8'h3C, "countWrite");
      applyStimulus(1'b0, IOB + 32'd8, 32'h0, 8'h3C, "countRead0");
      applyStimulus(1'b0, IOB + 32'd8, 32'h0, 8'h3C, "countRead1");
      applyStimulus(1'b0, IOB + 32'd8, 32'h0, 8'h3C, "countWrap");
      applyReset();
      applyStimulus(1'b1, DB + 32'd2, 32'h1234_5678, 8'h00, "misalignedWrite");
      applyStimulus(1'b0, DB, 32'h0, 8'h00, "misalignedRamUnchanged");
      applyStimulus(1'b0, DB + 32'd8, 32'h0, 8'h00, "errorSticky");
      applyReset();
      applyStimulus(1'b0, DB, 32'h0, 8'h00, "errorCleared");

      for (int i = 0; i < 600; i++) begin
         pins = ($urandom_range(0, 3) == 0) ? GW'($urandom) : gpio_in;
         if (i % 100 == 99) applyReset();
         else applyStimulus($urandom_range(0, 2) == 0, randomAddress(), $urandom,
                            pins, "random");
      end

      @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboardDrain pending=%0d required=0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder end of the core's data-memory bus. It answers every `MemWrite`/`Address`/`WriteData` transaction the core issues and returns `ReadData` in the same cycle, which the single-cycle datapath requires. It decodes a word-addressed RAM region and a small memory-mapped I/O region (GPIO out, synchronized GPIO in, cycle counter). It also flags illegal accesses. It sits beside the core at the top level, replacing the bare data memory.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bus word width
- `MEMORY_DEPTH`, 32, RAM size in words
- `DATA_BASE`, 32'h1001_0000, RAM base byte address
- `IO_BASE`, 32'h1001_0400, I/O region base byte address
- `GPIO_WIDTH`, 8, GPIO port width (1..32)

Ports:
- `clk` input 1, single clock, rising edge
- `reset` input 1, asynchronous, active-low
- `MemWrite` input 1, write strobe for the current cycle
- `Address` input 32, byte address from the core ALU
- `WriteData` input 32, store data
- `ReadData` output 32, load data, combinational
- `gpio_in` input GPIO_WIDTH, asynchronous external pins
- `gpio_out` output GPIO_WIDTH, registered output port
- `bus_error` output 1, sticky illegal-access flag

## Operation
- Decode:
  - RAM hit when `DATA_BASE <= Address < DATA_BASE + 4*MEMORY_DEPTH`; word index = `(Address - DATA_BASE) >> 2`.
  - I/O hit when `IO_BASE <= Address < IO_BASE + 16`.
  - Anything else is unmapped.
- I/O offsets:
  - +0 GPIO_OUT: read/write, low GPIO_WIDTH bits used, upper bits read 0.
  - +4 GPIO_IN: read-only, returns synchronized pins zero-extended; writes ignored.
  - +8 CYCLE_COUNT: read/write.
  - +C ID: read-only constant 32'hDB05_0001.
- Misaligned access (`Address[1:0] != 0`), unmapped access, or a write to a read-only register is an illegal access:
  - `ReadData` = 0.
  - The write has no effect.
  - `bus_error` is set at the next rising edge and stays set until reset.
- A read from an unmapped address sets `bus_error` only when `MemWrite`=1 or the address is misaligned. Plain unmapped reads are legal and return 0, because the core presents ALU results on `Address` every cycle.
- CYCLE_COUNT:
  - Increments by 1 each cycle and wraps 32'hFFFF_FFFF to 0.
  - A write loads `WriteData`; the write wins over the increment that cycle.

## Timing
- Reads are combinational: `ReadData` is valid in the same cycle as `Address`, with zero cycles of latency.
- Writes commit on the rising edge of `clk` while `MemWrite`=1.
- A read during a write to the same location returns the old value; the new value is visible from the next cycle.
- `gpio_in` passes through a 2-flop synchronizer. A pin change before edge N is readable after edge N+1 (2-edge latency).
- CYCLE_COUNT reads the pre-edge value. A write of X at edge N reads X in cycle N+1 and X+1 in cycle N+2.
- Reset (asserted low, asynchronous, effective mid-cycle and mid-write):
  - All RAM words = 0.
  - `gpio_out` = 0.
  - Synchronizer flops = 0.
  - CYCLE_COUNT = 0.
  - `bus_error` = 0.
  - `ReadData` reflects the cleared state immediately.
  - A write in flight when reset asserts is discarded.
- Release is synchronous in effect: the first write and the first count increment happen on the first rising edge with `reset`=1.

## Configuration
- `DBUS_CYCLE_COUNTER_EN`
  - Defined: CYCLE_COUNT is implemented as above.
  - Undefined: no counter flops. Offset +8 reads 0, and a write to +8 is illegal (sets `bus_error`).
  - The ID register's low byte is 8'h01 when defined and 8'h00 when undefined.

## Structure
- Package `dbus_pkg`:
  - Default base addresses.
  - I/O offset constants (`IO_GPIO_OUT`, `IO_GPIO_IN`, `IO_CYCLE_COUNT`, `IO_ID`).
  - ID constant.
  - Typedef for the decode result: enum `{HIT_RAM, HIT_IO, HIT_NONE}`.
- Sub-module `sync_2ff`: parameterized-width two-flop synchronizer with asynchronous active-low reset, instantiated once for `gpio_in`.

## Test plan
- Reset, then read `DATA_BASE`+8 -> `ReadData`=0, `bus_error`=0, `gpio_out`=0.
- Write 32'hCAFE_F00D to `DATA_BASE`+4 -> same-cycle read returns 0; next cycle returns 32'hCAFE_F00D; `DATA_BASE`+8 still 0.
- Write 32'h1A5 to `IO_BASE`+0 with GPIO_WIDTH=8 -> `gpio_out`=8'hA5 after the edge; read returns 32'h0000_00A5.
- Set `gpio_in`=8'h3C before edge N -> read of `IO_BASE`+4 returns 0 after edge N and 32'h3C after edge N+1.
- Write 32'hFFFF_FFFE to CYCLE_COUNT -> reads FFFF_FFFE, FFFF_FFFF, then 0 over the next three cycles. With the macro undefined: the read is 0 and `bus_error`=1.
- Write to `DATA_BASE`+2 (misaligned), then assert `reset` mid-cycle -> RAM unchanged, `bus_error`=1 after the edge, then 0 immediately on reset assertion.
